reg_bank_stack: RTL and testbench

REG_BANK_STACK -- requirements
Module: reg_bank_stack

---
 rtl/reg_bank_stack_pkg.sv | 17 +
 rtl/reg_bank_stack_stack_ctrl.sv | 64 ++++++
 rtl/reg_bank_stack.sv | 98 +++++++++
 tb/tb_reg_bank_stack.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_stack_pkg.sv
// Shared CPU definitions: stack command encodings and register-bank sizing helpers.
package reg_bank_stack_pkg;

  // Stack-pointer commands, shared by the control unit and the register bank.
  typedef enum logic [1:0] {
    SP_NOP   = 2'b00,
    SP_PUSH  = 2'b01,
    SP_POP   = 2'b10,
    SP_ENTER = 2'b11
  } sp_op_e;

  // Address width for a bank of n registers, never narrower than one bit.
  function automatic int addr_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_stack_stack_ctrl.sv
// SP/FP update requests and the sticky stack error flag.
module stack_ctrl
  import reg_bank_stack_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter logic [DATA_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sp_op,
  input  logic [DATA_W-1:0] sp_cur,
  input  logic              wr_sp,
  input  logic              wr_fp,
  input  logic              err_clr,
  output logic              sp_upd,
  output logic [DATA_W-1:0] sp_nxt,
  output logic              fp_upd,
  output logic              stack_err
);

  sp_op_e op;
  logic   err_set;
  logic   err_d;
  logic   err_q;

  assign op = sp_op_e'(sp_op);

  // Decide the SP/FP update; a general write to the same target discards the command.
  always_comb begin
    sp_upd  = 1'b0;
    sp_nxt  = sp_cur;
    fp_upd  = 1'b0;
    err_set = 1'b0;
    unique case (op)
      SP_PUSH: if (!wr_sp) begin
        if (sp_cur == '0) err_set = 1'b1;
        else begin
          sp_upd = 1'b1;
          sp_nxt = sp_cur - 1'b1;
        end
      end
      SP_POP: if (!wr_sp) begin
        if (sp_cur == SP_RESET) err_set = 1'b1;
        else begin
          sp_upd = 1'b1;
          sp_nxt = sp_cur + 1'b1;
        end
      end
      SP_ENTER: if (!wr_fp) fp_upd = 1'b1;
      default: ;
    endcase
    // A new error outranks a simultaneous clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign stack_err = err_q;

endmodule

// File: rtl/reg_bank_stack.sv
// Register bank with two combinational read ports, one write port, and SP/FP stack support.
module reg_bank_stack
  import reg_bank_stack_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                NREGS    = 8,
  parameter int                SP_IDX   = 4,
  parameter int                FP_IDX   = 5,
  parameter logic [DATA_W-1:0] SP_RESET = '1,
  parameter int                BYPASS   = 1,
  localparam int               ADDR_W   = addr_w_f(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [1:0]        sp_op,
  output logic [DATA_W-1:0] sp_out,
  output logic              stack_err,
  input  logic              err_clr
);

  // Refuse to elaborate with overlapping or out-of-range SP/FP indices.
  if (SP_IDX == FP_IDX || SP_IDX >= NREGS || FP_IDX >= NREGS || SP_IDX < 0 || FP_IDX < 0) begin : g_bad_idx
    $error("reg_bank_stack: SP_IDX and FP_IDX must be distinct and below NREGS");
  end

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_ok;
  logic              wr_sp;
  logic              wr_fp;
  logic              sp_upd;
  logic              fp_upd;
  logic [DATA_W-1:0] sp_nxt;

  assign wr_ok = write_enable && (int'(write_addr) < NREGS);
  assign wr_sp = wr_ok && (int'(write_addr) == SP_IDX);
  assign wr_fp = wr_ok && (int'(write_addr) == FP_IDX);

  stack_ctrl #(
    .DATA_W   (DATA_W),
    .SP_RESET (SP_RESET)
  ) u_stack_ctrl (
    .clk       (clk),
    .rst       (rst),
    .sp_op     (sp_op),
    .sp_cur    (regs_q[SP_IDX]),
    .wr_sp     (wr_sp),
    .wr_fp     (wr_fp),
    .err_clr   (err_clr),
    .sp_upd    (sp_upd),
    .sp_nxt    (sp_nxt),
    .fp_upd    (fp_upd),
    .stack_err (stack_err)
  );

  // Next register contents: general write plus whichever stack update survived arbitration.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      regs_d[i] = regs_q[i];
      if (wr_ok && int'(write_addr) == i) regs_d[i] = write_data;
    end
    if (sp_upd) regs_d[SP_IDX] = sp_nxt;
    if (fp_upd) regs_d[FP_IDX] = regs_q[SP_IDX];
  end

  // Register storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      // NOTE: this bank is small flop storage with a defined reset image, so every entry is reset;
      // a RAM-based bank would not be. Sequential state uses non-blocking assignments only.
      if (rst) regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      else     regs_q[i] <= regs_d[i];
    end
  end

  // Read muxes; unimplemented addresses return zero, bypass covers the general write port only.
  always_comb begin
    out_1 = '0;
    out_2 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(rd_addr1) == i)
        out_1 = (BYPASS != 0 && wr_ok && write_addr == rd_addr1) ? write_data : regs_q[i];
      if (int'(rd_addr2) == i)
        out_2 = (BYPASS != 0 && wr_ok && write_addr == rd_addr2) ? write_data : regs_q[i];
    end
  end

  assign sp_out = regs_q[SP_IDX];

endmodule

// File: tb/tb_reg_bank_stack.sv
// Self-checking bench: default instance (8 regs, bypass) and a 6-register no-bypass instance.
module tb_reg_bank_stack;
  import reg_bank_stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rd_addr1 = '0, rd_addr2 = '0, write_addr = '0;
  logic       write_enable = 1'b0, err_clr = 1'b0;
  logic [7:0] write_data = '0;
  logic [1:0] sp_op = SP_NOP;

  logic [7:0] a_out1, a_out2, a_sp, b_out1, b_out2, b_sp;
  logic       a_err, b_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  reg_bank_stack u_dut_a (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .out_1(a_out1), .out_2(a_out2), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data), .sp_op(sp_op),
    .sp_out(a_sp), .stack_err(a_err), .err_clr(err_clr)
  );

  reg_bank_stack #(.NREGS(6), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .out_1(b_out1), .out_2(b_out2), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data), .sp_op(sp_op),
    .sp_out(b_sp), .stack_err(b_err), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         nregs_m  [2] = '{8, 6};
  bit         bypass_m [2] = '{1'b1, 1'b0};
  logic [7:0] m_regs   [2][8];
  logic       m_err    [2];

  function automatic logic [7:0] model_read(input int k, input logic [2:0] addr);
    if (int'(addr) >= nregs_m[k]) return 8'h00;
    if (bypass_m[k] && write_enable && int'(write_addr) < nregs_m[k] && write_addr == addr)
      return write_data;
    return m_regs[k][addr];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) m_regs[k][i] = 8'h00;
        m_regs[k][4] = 8'hFF;
        m_err[k] = 1'b0;
      end else begin
        logic       wr_ok;
        logic [7:0] sp;
        logic       set;
        wr_ok = write_enable && (int'(write_addr) < nregs_m[k]);
        sp    = m_regs[k][4];
        set   = 1'b0;
        if (wr_ok) m_regs[k][write_addr] = write_data;
        case (sp_op)
          2'b01: if (!(wr_ok && write_addr == 3'd4)) begin
                   if (sp == 8'h00) set = 1'b1; else m_regs[k][4] = sp - 8'd1;
                 end
          2'b10: if (!(wr_ok && write_addr == 3'd4)) begin
                   if (sp == 8'hFF) set = 1'b1; else m_regs[k][4] = sp + 8'd1;
                 end
          2'b11: if (!(wr_ok && write_addr == 3'd5)) m_regs[k][5] = sp;
          default: ;
        endcase
        m_err[k] = set ? 1'b1 : (err_clr ? 1'b0 : m_err[k]);
      end
    end
  end

  // Compare process: mid-cycle, all outputs of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("a_out_1",     a_out1, model_read(0, rd_addr1));
      check("a_out_2",     a_out2, model_read(0, rd_addr2));
      check("a_sp_out",    a_sp,   m_regs[0][4]);
      check("a_stack_err", a_err,  m_err[0]);
      check("b_out_1",     b_out1, model_read(1, rd_addr1));
      check("b_out_2",     b_out2, model_read(1, rd_addr2));
      check("b_sp_out",    b_sp,   m_regs[1][4]);
      check("b_stack_err", b_err,  m_err[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_image(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = 3'(i);
      rd_addr2 = 3'(7 - i);
      #1;
      check({tag, "_a_rd"}, a_out1, (i == 4) ? 8'hFF : 8'h00);
      check({tag, "_b_rd"}, b_out1, (i == 4) ? 8'hFF : 8'h00);
      check({tag, "_err"},  a_err,  1'b0);
      step();
    end
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check_en = 1'b1;

    // Reset image.
    check_reset_image("reset");
    check("reset_sp", a_sp, 8'hFF);

    // Same-cycle write visibility.
    write_enable = 1'b1; write_addr = 3'd2; write_data = 8'h3C; rd_addr1 = 3'd2;
    #1;
    check("bypass_a_pre", a_out1, 8'h3C);
    check("bypass_b_pre", b_out1, 8'h00);
    step();
    write_enable = 1'b0;
    #1;
    check("bypass_a_post", a_out1, 8'h3C);
    check("bypass_b_post", b_out1, 8'h3C);
    step();

    // PUSH x3 then ENTER.
    rst = 1'b1; step(); rst = 1'b0;
    sp_op = SP_PUSH; step(); step(); step();
    sp_op = SP_ENTER; step();
    sp_op = SP_NOP; rd_addr1 = 3'd5;
    #1;
    check("enter_sp", a_sp, 8'hFC);
    check("enter_fp", a_out1, 8'hFC);
    check("enter_err", a_err, 1'b0);
    step();

    // Underflow at SP=0, clear, overflow at SP_RESET.
    write_enable = 1'b1; write_addr = 3'd4; write_data = 8'h00; step();
    write_enable = 1'b0; sp_op = SP_PUSH; step();
    sp_op = SP_NOP; #1;
    check("push0_sp", a_sp, 8'h00);
    check("push0_err", a_err, 1'b1);
    err_clr = 1'b1; step(); err_clr = 1'b0; #1;
    check("clr_err", a_err, 1'b0);
    write_enable = 1'b1; write_data = 8'hFF; step();
    write_enable = 1'b0; sp_op = SP_POP; step();
    sp_op = SP_NOP; #1;
    check("popmax_sp", a_sp, 8'hFF);
    check("popmax_err", a_err, 1'b1);

    // Clear and new error in the same cycle: error wins.
    write_enable = 1'b1; write_data = 8'h00; step();
    write_enable = 1'b0; sp_op = SP_PUSH; err_clr = 1'b1; step();
    sp_op = SP_NOP; err_clr = 1'b0; #1;
    check("clr_vs_set_err", b_err, 1'b1);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Write/stack arbitration.
    sp_op = SP_PUSH; write_enable = 1'b1; write_addr = 3'd4; write_data = 8'h80; step();
    sp_op = SP_NOP; write_enable = 1'b0; #1;
    check("wr_wins_sp", a_sp, 8'h80);
    check("wr_wins_err", a_err, 1'b0);
    sp_op = SP_PUSH; write_enable = 1'b1; write_addr = 3'd1; write_data = 8'h11; step();
    sp_op = SP_NOP; write_enable = 1'b0; rd_addr1 = 3'd1; #1;
    check("alongside_sp", a_sp, 8'h7F);
    check("alongside_r1", a_out1, 8'h11);
    sp_op = SP_ENTER; write_enable = 1'b1; write_addr = 3'd5; write_data = 8'h55; step();
    sp_op = SP_NOP; write_enable = 1'b0; rd_addr1 = 3'd5; #1;
    check("wr_wins_fp", b_out1, 8'h55);

    // High and out-of-range indices, then reset mid-sequence.
    write_enable = 1'b1; write_addr = 3'd6; write_data = 8'hAA; rd_addr1 = 3'd6; rd_addr2 = 3'd7;
    #1;
    check("oor_b_pre", b_out1, 8'h00);
    check("hi_a_bypass", a_out1, 8'hAA);
    step();
    write_addr = 3'd7; write_data = 8'hBB; sp_op = SP_PUSH; step();
    write_enable = 1'b0; sp_op = SP_NOP; #1;
    check("hi_a_r6", a_out1, 8'hAA);
    check("hi_a_r7", a_out2, 8'hBB);
    check("oor_b_r6", b_out1, 8'h00);
    check("oor_b_r7", b_out2, 8'h00);
    check("hi_a_sp", a_sp, 8'h7E);
    rst = 1'b1; write_enable = 1'b1; write_addr = 3'd3; write_data = 8'h99; sp_op = SP_PUSH;
    step();
    rst = 1'b0; write_enable = 1'b0; sp_op = SP_NOP;
    check_reset_image("rerst");
    check("rerst_sp", a_sp, 8'hFF);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
